// File: rtl/bht_btb_access_ctrl.sv
// Single-port BHT/BTB RAM sequencer: arbitrates fetch lookups against read-modify-write branch updates.
// Optional BHT_BTB_INIT_EN: after reset, zero all 64 entries before fetch is admitted.
module bht_btb_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        lk_req,
    input  logic [10:0] lk_pc,
    output logic        lk_stall,
    output logic        lk_resp_valid,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [10:0] lk_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [10:0] upd_pc,
    input  logic        upd_taken,
    input  logic [10:0] upd_target,
    output logic [5:0]  mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam int unsigned TAG_W = 5;
    localparam int unsigned CTR_W = 2;
    localparam int unsigned PAD_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPD_WR = 2'd1,
        ST_INIT   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_buf_full;
    logic [10:0]        r_buf_pc;
    logic               r_buf_taken;
    logic [10:0]        r_buf_target;
    logic               r_resp_valid;
    logic [TAG_W-1:0]   r_lk_tag;
`ifdef BHT_BTB_INIT_EN
    logic [5:0]         r_init_addr;
`endif

    logic               w_word_clean;
    logic               w_upd_hit;
    logic [CTR_W-1:0]   w_old_ctr;
    logic [CTR_W-1:0]   w_new_ctr;
    logic [31:0]        w_upd_word;
    logic               w_lk_hit;

    // A word with stray upper bits is treated as not valid.
    assign w_word_clean = (mem_rd_data[31:19] == '0);
    assign w_upd_hit    = w_word_clean && mem_rd_data[16] && (mem_rd_data[15:11] == r_buf_pc[10:6]);
    assign w_old_ctr    = mem_rd_data[18:17];
    assign w_upd_word   = {PAD_W'(0), w_new_ctr, 1'b1, r_buf_pc[10:6], r_buf_target};

    always_comb begin
        w_new_ctr = r_buf_taken ? 2'b10 : 2'b01;
        if (w_upd_hit) begin
            if (r_buf_taken) begin
                w_new_ctr = (w_old_ctr == 2'b11) ? 2'b11 : w_old_ctr + 2'd1;
            end else begin
                w_new_ctr = (w_old_ctr == 2'b00) ? 2'b00 : w_old_ctr - 2'd1;
            end
        end
    end

    assign w_lk_hit      = r_resp_valid && w_word_clean && mem_rd_data[16]
                           && (mem_rd_data[15:11] == r_lk_tag);
    assign lk_resp_valid = r_resp_valid;
    assign lk_hit        = w_lk_hit;
    assign lk_taken      = w_lk_hit && mem_rd_data[18];
    assign lk_target     = w_lk_hit ? mem_rd_data[10:0] : 11'd0;
    assign upd_ready     = !r_buf_full && (r_state != ST_INIT);

    // RAM port steering; a pending write is suppressed while reset is asserted.
    always_comb begin
        mem_addr    = lk_pc[5:0];
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        lk_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_buf_full) begin
                    mem_addr = r_buf_pc[5:0];
                    lk_stall = 1'b1;
                end
            end
            ST_UPD_WR: begin
                mem_addr    = r_buf_pc[5:0];
                mem_wr_en   = 1'b1;
                mem_wr_data = w_upd_word;
                lk_stall    = 1'b1;
            end
`ifdef BHT_BTB_INIT_EN
            ST_INIT: begin
                mem_addr  = r_init_addr;
                mem_wr_en = 1'b1;
                lk_stall  = 1'b1;
            end
`endif
            default: begin
                lk_stall = 1'b1;
            end
        endcase
        if (reset) begin
            mem_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef BHT_BTB_INIT_EN
            r_state     <= ST_INIT;
            r_init_addr <= 6'd0;
`else
            r_state     <= ST_IDLE;
`endif
            r_buf_full   <= 1'b0;
            r_buf_pc     <= 11'd0;
            r_buf_taken  <= 1'b0;
            r_buf_target <= 11'd0;
            r_resp_valid <= 1'b0;
            r_lk_tag     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (upd_valid && upd_ready) begin
                r_buf_full   <= 1'b1;
                r_buf_pc     <= upd_pc;
                r_buf_taken  <= upd_taken;
                r_buf_target <= upd_target;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_buf_full) begin
                        r_state <= ST_UPD_WR;
                    end else if (lk_req) begin
                        r_resp_valid <= 1'b1;
                        r_lk_tag     <= lk_pc[10:6];
                    end
                end
                ST_UPD_WR: begin
                    r_buf_full <= 1'b0;
                    r_state    <= ST_IDLE;
                end
`ifdef BHT_BTB_INIT_EN
                ST_INIT: begin
                    r_init_addr <= r_init_addr + 6'd1;
                    if (r_init_addr == 6'd63) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bht_btb_access_ctrl.sv
// Scoreboard bench for bht_btb_access_ctrl with a behavioural 1-cycle-latency RAM.
module tb_bht_btb_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        lk_req;
    logic [10:0] lk_pc;
    logic        lk_stall;
    logic        lk_resp_valid;
    logic        lk_hit;
    logic        lk_taken;
    logic [10:0] lk_target;
    logic        upd_valid;
    logic        upd_ready;
    logic [10:0] upd_pc;
    logic        upd_taken;
    logic [10:0] upd_target;
    logic [5:0]  mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    bht_btb_access_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .lk_req       (lk_req),
        .lk_pc        (lk_pc),
        .lk_stall     (lk_stall),
        .lk_resp_valid(lk_resp_valid),
        .lk_hit       (lk_hit),
        .lk_taken     (lk_taken),
        .lk_target    (lk_target),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [64] = '{default: 32'd0};
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_addr];
    end

    typedef struct {
        logic        hit;
        logic        taken;
        logic [10:0] tgt;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [10:0] pc;
        logic        taken;
        logic [10:0] tgt;
        int          cyc;
    } upd_t;

    resp_t       resp_q[$];
    upd_t        pend_q[$];
    logic [31:0] model [64];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_lk_acc = 0;
    int          n_resp = 0;
    logic        last_lk_acc = 1'b0;
    logic        last_upd_acc = 1'b0;
    logic        last_stall = 1'b0;
    logic [31:0] saved;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        failures++;
        $error("FAIL %s: observed timeout/unexpected event expected none", tag);
    endtask

    function automatic logic [31:0] model_upd(input logic [31:0] old, input logic [10:0] pc,
                                              input logic tk, input logic [10:0] tgt);
        logic hit;
        int   c;
        hit = old[16] && (old[15:11] == pc[10:6]);
        c   = int'(old[18:17]);
        if (!hit)     c = tk ? 2 : 1;
        else if (tk)  c = (c < 3) ? c + 1 : 3;
        else          c = (c > 0) ? c - 1 : 0;
        return {13'd0, 2'(c), 1'b1, pc[10:6], tgt};
    endfunction

    // Sampled at the falling edge: check responses/writes, then log new acceptances.
    task automatic monitor();
        resp_t       e;
        upd_t        u;
        logic [31:0] w;
        last_lk_acc  = 1'b0;
        last_upd_acc = 1'b0;
        last_stall   = lk_stall;
        if (lk_resp_valid) begin
            n_resp++;
            if (resp_q.size() == 0) fail_now("resp_unexpected");
            else begin
                e = resp_q.pop_front();
                check("lk_latency", 32'(cyc - e.cyc), 32'd1);
                check("lk_hit", 32'(lk_hit), 32'(e.hit));
                check("lk_taken", 32'(lk_taken), 32'(e.taken));
                check("lk_target", 32'(lk_target), 32'(e.tgt));
            end
        end else begin
            check("lk_idle_zero", 32'({lk_hit, lk_taken, lk_target}), 32'd0);
        end
        if (mem_wr_en) begin
            if (pend_q.size() == 0) fail_now("write_unexpected");
            else begin
                u = pend_q.pop_front();
                w = model_upd(model[u.pc[5:0]], u.pc, u.taken, u.tgt);
                check("wr_latency", 32'(cyc - u.cyc), 32'd2);
                check("wr_addr", 32'(mem_addr), 32'(u.pc[5:0]));
                check("wr_data", mem_wr_data, w);
                model[u.pc[5:0]] = w;
            end
        end
        if (lk_req && !lk_stall) begin
            w = model[lk_pc[5:0]];
            e.hit   = w[16] && (w[15:11] == lk_pc[10:6]);
            e.taken = e.hit && w[18];
            e.tgt   = e.hit ? w[10:0] : 11'd0;
            e.cyc   = cyc;
            resp_q.push_back(e);
            n_lk_acc++;
            last_lk_acc = 1'b1;
        end
        if (upd_valid && upd_ready) begin
            u.pc = upd_pc; u.taken = upd_taken; u.tgt = upd_target; u.cyc = cyc;
            pend_q.push_back(u);
            last_upd_acc = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_lookup(input logic [10:0] pc);
        int n = 0;
        lk_req = 1'b1;
        lk_pc  = pc;
        do begin tick(); n++; end while (!last_lk_acc && n < 100);
        if (!last_lk_acc) fail_now("lookup_accept_timeout");
        lk_req = 1'b0;
        tick();
    endtask

    task automatic do_update(input logic [10:0] pc, input logic tk, input logic [10:0] tgt);
        int n = 0;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        do begin tick(); n++; end while (!last_upd_acc && n < 100);
        if (!last_upd_acc) fail_now("update_accept_timeout");
        upd_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!upd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!upd_ready) fail_now("ready_timeout");
    endtask

    logic [10:0] a_pc  [3] = '{11'h041, 11'h082, 11'h0C3};
    logic        a_tk  [3] = '{1'b1, 1'b0, 1'b1};
    logic [10:0] a_tgt [3] = '{11'h111, 11'h222, 11'h333};

    initial begin
        for (int i = 0; i < 64; i++) model[i] = 32'd0;
        reset = 1'b1; lk_req = 1'b0; lk_pc = 11'd0;
        upd_valid = 1'b0; upd_pc = 11'd0; upd_taken = 1'b0; upd_target = 11'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_resp_valid", 32'(lk_resp_valid), 32'd0);
        check("rst_outputs", 32'({lk_hit, lk_taken, lk_target}), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
`ifndef BHT_BTB_INIT_EN
        @(negedge clk);
        check("post_rst_stall", 32'(lk_stall), 32'd0);
        check("post_rst_ready", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
`else
        wait_ready();
`endif
        // Cold lookup, then miss allocation
        do_lookup(11'h0A5);
        do_update(11'h0A5, 1'b1, 11'h123);
        check("alloc_word", ram[6'h25], 32'h0005_1123);
        do_lookup(11'h0A5);

        // Counter walks down and saturates
        do_update(11'h0A5, 1'b0, 11'h123);
        check("sat_ctr1", 32'(ram[6'h25][18:17]), 32'd1);
        do_update(11'h0A5, 1'b0, 11'h123);
        check("sat_ctr2", 32'(ram[6'h25][18:17]), 32'd0);
        do_update(11'h0A5, 1'b0, 11'h123);
        check("sat_ctr3", 32'(ram[6'h25][18:17]), 32'd0);
        do_lookup(11'h0A5);

        // Tag conflict replaces the entry
        do_update(11'h0E5, 1'b1, 11'h456);
        check("conflict_word", ram[6'h25], 32'h0005_1C56);
        do_lookup(11'h0A5);
        do_lookup(11'h0E5);

        // Arbitration: lookups held while updates stream in
        begin
            int u = 0;
            lk_req = 1'b1; lk_pc = 11'h041;
            upd_valid = 1'b1; upd_pc = a_pc[0]; upd_taken = a_tk[0]; upd_target = a_tgt[0];
            for (int i = 0; i < 9; i++) begin
                tick();
                check("arb_stall", 32'(last_stall), 32'((i % 3) != 0));
                if (last_upd_acc) begin
                    u++;
                    if (u < 3) begin
                        upd_pc = a_pc[u]; upd_taken = a_tk[u]; upd_target = a_tgt[u];
                    end else begin
                        upd_valid = 1'b0;
                    end
                end
            end
            lk_req = 1'b0;
            upd_valid = 1'b0;
            check("arb_updates", 32'(u), 32'd3);
            repeat (2) tick();
        end

        // Reset while the write is pending
        saved = ram[6'h25];
        begin
            int n = 0;
            upd_valid = 1'b1; upd_pc = 11'h0A5; upd_taken = 1'b0; upd_target = 11'h7FF;
            do begin tick(); n++; end while (!last_upd_acc && n < 100);
            if (!last_upd_acc) fail_now("rmw_accept_timeout");
            upd_valid = 1'b0;
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mid_ready", 32'(upd_ready), 32'd0);
        @(posedge clk); #1;
        pend_q.delete();
        resp_q.delete();
`ifndef BHT_BTB_INIT_EN
        @(negedge clk);
        check("rst_buf_drop", 32'(upd_ready), 32'd1);
        @(posedge clk); #1;
`endif
        reset = 1'b0;
        wait_ready();
        tick();
        check("rst_entry_kept", ram[6'h25], saved);
        do_lookup(11'h0E5);

        check("resp_count", 32'(n_resp), 32'(n_lk_acc));
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);
        check("pend_q_empty", 32'(pend_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
